// File: rtl/lzd_denorm_pipe.sv
// lzd_denorm_pipe
//   Three-stage denormalizer: rebuilds a fixed-point value from a normalized
//   mantissa and the shift count produced by a leading-zero detector, i.e.
//   out_q = in_m >> in_p, with a sticky flag collecting every bit shifted out.
//
//   Ports
//     clk, rst              rising-edge clock, asynchronous active-high reset
//     in_valid / in_ready   upstream handshake (in_ready = pipeline advance)
//     in_m [W-1:0]          normalized mantissa
//     in_p [SW-1:0]         right-shift amount
//     in_v                  LZD valid; 0 means the original value was zero
//     out_valid / out_ready downstream handshake
//     out_q [W-1:0]         denormalized value
//     out_sticky            OR of all bits shifted out
//     out_zero              out_q == 0
//
//   Stage 1 registers the beat and folds the "effective zero" cases (in_v=0 or
//   in_p >= W) into data=0. Stage 2 shifts right by the byte-multiple part of
//   the count, stage 3 by the remaining 0..7 bits. All stages advance together;
//   bubbles are not collapsed.
module lzd_denorm_pipe #(
  parameter int unsigned W  = 48,
  parameter int unsigned SW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_m,
  input  logic [SW-1:0] in_p,
  input  logic          in_v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_q,
  output logic          out_sticky,
  output logic          out_zero
);

  localparam logic [SW:0]  W_EXT = (SW+1)'(W);
  localparam logic [W-1:0] ONES  = '1;

  logic adv;

  // Stage 1
  logic          s1_valid_q, s1_valid_d;
  logic [W-1:0]  s1_data_q,  s1_data_d;
  logic          s1_sticky_q, s1_sticky_d;
  logic [SW-1:0] s1_p_q,     s1_p_d;

  // Stage 2
  logic          s2_valid_q, s2_valid_d;
  logic [W-1:0]  s2_data_q,  s2_data_d;
  logic          s2_sticky_q, s2_sticky_d;
  logic [2:0]    s2_p_q,     s2_p_d;

  // Stage 3
  logic          s3_valid_q, s3_valid_d;
  logic [W-1:0]  s3_data_q,  s3_data_d;
  logic          s3_sticky_q, s3_sticky_d;
  logic          s3_zero_q,  s3_zero_d;

  logic [SW-1:0] coarse_sh;
  logic [W-1:0]  coarse_drop;
  logic [W-1:0]  fine_drop;

  assign adv      = !s3_valid_q || out_ready;
  assign in_ready = adv;

  assign out_valid  = s3_valid_q;
  assign out_q      = s3_data_q;
  assign out_sticky = s3_sticky_q;
  assign out_zero   = s3_zero_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_sticky_d = s1_sticky_q;
    s1_p_d      = s1_p_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_sticky_d = s2_sticky_q;
    s2_p_d      = s2_p_q;
    s3_valid_d  = s3_valid_q;
    s3_data_d   = s3_data_q;
    s3_sticky_d = s3_sticky_q;
    s3_zero_d   = s3_zero_q;

    coarse_sh   = {s1_p_q[SW-1:3], 3'b000};
    coarse_drop = s1_data_q & ~(ONES << coarse_sh);
    fine_drop   = s2_data_q & ~(ONES << s2_p_q);

    if (adv) begin
      // Stage 1: out-of-range counts and LZD-invalid beats become a zero
      // result with the whole mantissa counted as shifted out.
      s1_valid_d = in_valid;
      if (!in_v || ({1'b0, in_p} >= W_EXT)) begin
        s1_data_d   = '0;
        s1_sticky_d = |in_m;
        s1_p_d      = '0;
      end else begin
        s1_data_d   = in_m;
        s1_sticky_d = 1'b0;
        s1_p_d      = in_p;
      end

      // Stage 2: coarse shift by 8 * p[SW-1:3]
      s2_valid_d  = s1_valid_q;
      s2_data_d   = s1_data_q >> coarse_sh;
      s2_sticky_d = s1_sticky_q | (|coarse_drop);
      s2_p_d      = s1_p_q[2:0];

      // Stage 3: fine shift by p[2:0]
      s3_valid_d  = s2_valid_q;
      s3_data_d   = s2_data_q >> s2_p_q;
      s3_sticky_d = s2_sticky_q | (|fine_drop);
      s3_zero_d   = ((s2_data_q >> s2_p_q) == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_sticky_q <= 1'b0;
      s1_p_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_sticky_q <= 1'b0;
      s2_p_q      <= '0;
      s3_valid_q  <= 1'b0;
      s3_data_q   <= '0;
      s3_sticky_q <= 1'b0;
      s3_zero_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_sticky_q <= s1_sticky_d;
      s1_p_q      <= s1_p_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_sticky_q <= s2_sticky_d;
      s2_p_q      <= s2_p_d;
      s3_valid_q  <= s3_valid_d;
      s3_data_q   <= s3_data_d;
      s3_sticky_q <= s3_sticky_d;
      s3_zero_q   <= s3_zero_d;
    end
  end

endmodule

// File: tb/tb_lzd_denorm_pipe.sv
// Scoreboard bench for lzd_denorm_pipe: the driver pushes the expected
// {q, sticky, zero} when a beat is accepted; the monitor pops on each output
// transfer, and also checks hold stability and the in_ready relation.
module tb_lzd_denorm_pipe;
  localparam int W  = 48;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_m;
  logic [SW-1:0] in_p;
  logic          in_v;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_q;
  logic          out_sticky;
  logic          out_zero;

  lzd_denorm_pipe #(.W(W), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_m(in_m), .in_p(in_p), .in_v(in_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_sticky(out_sticky), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int ready_mode = 0; // 0: always ready, 1: random, 2: driven by main
  logic [W+1:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [W-1:0] m, input logic [SW-1:0] p, input logic v,
                      input logic [W-1:0] eq, input logic es, input logic ez);
    int  budget;
    bit  done;
    budget = 0;
    done   = 0;
    in_valid = 1'b1;
    in_m = m;
    in_p = p;
    in_v = v;
    while (!done) begin
      #1;
      if (in_ready) begin
        sb.push_back({eq, es, ez});
        done = 1;
      end else if (budget > 200) begin
        fail_now("accept_timeout");
        done = 1;
      end
      budget++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int c;
    c = 0;
    while (sb.size() != 0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (ready_mode == 0)      out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor
  initial begin : monitor
    logic [W+1:0] held;
    logic [W+1:0] e;
    bit held_v;
    held_v = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held_v = 0;
        continue;
      end
      chk("in_ready_rel", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (held_v) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_data", {14'd0, out_q, out_sticky, out_zero}, {14'd0, held});
      end
      held_v = 0;
      if (out_valid && !out_ready) begin
        held   = {out_q, out_sticky, out_zero};
        held_v = 1;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got q=%h s=%b z=%b, expected none", out_q, out_sticky, out_zero);
        end else begin
          e = sb.pop_front();
          chk("result", {14'd0, out_q, out_sticky, out_zero}, {14'd0, e});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    int out_before;
    logic [63:0] r;
    logic [W-1:0] a;
    logic [W-1:0] m;
    int lz;

    rst = 1'b1;
    in_valid = 1'b0;
    in_m = '0;
    in_p = '0;
    in_v = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid",  {63'd0, out_valid}, 64'd0);
    chk("rst_out_q",      {16'd0, out_q}, 64'd0);
    chk("rst_out_sticky", {63'd0, out_sticky}, 64'd0);
    chk("rst_out_zero",   {63'd0, out_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    // Latency with no stall
    send(48'h800000000000, 6'd47, 1'b1, 48'h000000000001, 1'b0, 1'b0);
    #1;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    chk("latency", 64'(cnt), 64'd3);
    @(negedge clk);
    drain(50);

    // Directed vectors, back-to-back
    send(48'hC00000000000, 6'd46, 1'b1, 48'h000000000003, 1'b0, 1'b0);
    send(48'hA00000000000, 6'd45, 1'b1, 48'h000000000005, 1'b0, 1'b0);
    send(48'hFFFFFFFFFFFF, 6'd0,  1'b1, 48'hFFFFFFFFFFFF, 1'b0, 1'b0);
    send(48'h800000000001, 6'd63, 1'b1, 48'h000000000000, 1'b1, 1'b1);
    send(48'h000000000000, 6'd0,  1'b0, 48'h000000000000, 1'b0, 1'b1);
    send(48'h800000000003, 6'd1,  1'b1, 48'h400000000001, 1'b1, 1'b0);
    send(48'h800000000000, 6'd48, 1'b1, 48'h000000000000, 1'b1, 1'b1);
    send(48'hFFFFFFFFFFFF, 6'd47, 1'b1, 48'h000000000001, 1'b1, 1'b0);
    send(48'h800000000100, 6'd8,  1'b1, 48'h008000000001, 1'b0, 1'b0);
    send(48'h8000000000FF, 6'd9,  1'b1, 48'h004000000000, 1'b1, 1'b0);
    send(48'h000000000123, 6'd5,  1'b0, 48'h000000000000, 1'b1, 1'b1);
    send(48'h000000000F00, 6'd4,  1'b1, 48'h0000000000F0, 1'b0, 1'b0);
    send(48'h800000000080, 6'd40, 1'b1, 48'h000000000080, 1'b1, 1'b0);
    drain(100);

    // Backpressure: 8 beats, out_ready low for cycles 4..7
    ready_mode = 2;
    out_before = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(48'h800000000000 | (48'(i) << 4), 6'd4, 1'b1,
               48'h080000000000 | 48'(i), 1'b0, 1'b0);
      end
      begin
        for (int c = 0; c < 16; c++) begin
          out_ready = !(c >= 4 && c <= 7);
          if (c >= 4 && c <= 7) begin
            #1;
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
          end
          @(negedge clk);
        end
      end
    join
    ready_mode = 0;
    drain(100);
    chk("bp_count", 64'(n_out - out_before), 64'd8);

    // Reset with three beats in flight
    ready_mode = 2;
    out_ready = 1'b0;
    send(48'h800000000000, 6'd0, 1'b1, 48'h800000000000, 1'b0, 1'b0);
    send(48'h400000000000, 6'd0, 1'b1, 48'h400000000000, 1'b0, 1'b0);
    send(48'h200000000000, 6'd0, 1'b1, 48'h200000000000, 1'b0, 1'b0);
    #1;
    chk("inflight_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_q", {16'd0, out_q}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    ready_mode = 0;
    out_before = n_out;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("no_stale_valid", {63'd0, out_valid}, 64'd0);
      chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
    end
    chk("no_stale_count", 64'(n_out - out_before), 64'd0);

    // Random round trip: a normalized by its leading-zero count
    ready_mode = 1;
    for (int k = 0; k < 10000; k++) begin
      r = {$urandom(), $urandom()};
      a = r[W-1:0] >> $urandom_range(0, W - 1);
      if (a == '0) begin
        send('0, '0, 1'b0, '0, 1'b0, 1'b1);
      end else begin
        lz = 0;
        for (int b = W - 1; b >= 0; b--) begin
          if (a[b]) break;
          lz++;
        end
        m = a << lz;
        send(m, SW'(lz), 1'b1, a, 1'b0, 1'b0);
      end
    end
    ready_mode = 0;
    drain(500);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lzd_denorm_pipe.md
Name: lzd_denorm_pipe

Overview:
- Pipelined denormalizer: the inverse of the leading-zero-detect/normalize step in the Box-Muller datapath.
- Takes a normalized 48-bit mantissa plus the 6-bit shift count and valid flag produced by the LZD. Shifts the mantissa back right to rebuild the fixed-point value.
- Sits at the output of the log/sqrt range-reduction path, before the sample formatter.
- Valid/ready handshake on both sides, 3-cycle latency, with backpressure.

Parameters:
- W, 48, data width of mantissa and result.
- SW, 6, shift-count width; must satisfy 2^SW >= W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_m  in  W  normalized mantissa (MSB set when in_v=1).
- in_p  in  SW  right-shift amount (LZD position output).
- in_v  in  1  LZD valid: 0 means the original value was zero.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_q  out  W  denormalized value, in_m >> in_p.
- out_sticky  out  1  OR of all bits shifted out.
- out_zero  out  1  result is exactly zero.

Behaviour:
- Reset: asynchronous, active-high, on rst. Clears all stage valid bits and data registers.
  - out_valid=0, out_q=0, out_sticky=0, out_zero=0.
  - in_ready=1 once rst is deasserted.
- Pipeline advance: adv = !out_valid | out_ready. All three stages move together when adv=1 and hold when adv=0.
- in_ready = adv, combinational. A beat is accepted when in_valid & in_ready.
- Bubbles are not collapsed, so an empty stage still stalls while the output is blocked.
- Stage 1: register in_m, in_p, in_v and valid.
  - Force an effective zero when in_v=0 or in_p >= W: data=0, sticky = |in_m.
- Stage 2: coarse shift right by 8*p[SW-1:3]. Accumulate sticky from the bits dropped.
- Stage 3: fine shift right by p[2:0]. Accumulate sticky. out_zero = (q==0).
- Latency: 3 cycles from acceptance to out_valid when there is no stall. Throughput is 1 beat/cycle.
- Under a stall, out_q, out_sticky and out_zero stay stable, and out_valid stays high until out_ready.
- Shift rule: logical right shift, zero-fill. p=0 passes in_m unchanged with sticky=0.
- Boundaries:
  - p=W-1 leaves only the original LSB position.
  - p in [W, 2^SW-1] gives q=0, with sticky = |in_m.
  - in_v=0 gives q=0 and out_zero=1, whatever in_m is.
- Simultaneous accept and drain in the same cycle is legal; there is no loss and no duplication.
- rst asserted mid-stream discards all in-flight beats immediately. No partial result appears after reset.
- in_m with MSB=0 while in_v=1 is not flagged. The shift is applied as-is.

Test Plan:
- Reset: rst=1 mid-stream with 3 beats in flight -> out_valid=0 within the same cycle. After release, in_ready=1 and no stale output appears.
- Round trip:
  - in_m=0x800000000000, p=47, v=1 -> 3 cycles later out_q=1, sticky=0, zero=0.
  - in_m=0xC00000000000, p=46, v=1 -> out_q=3.
  - in_m=0xA00000000000, p=45 -> out_q=5.
- Boundaries:
  - p=0, in_m=0xFFFFFFFFFFFF -> out_q=0xFFFFFFFFFFFF, sticky=0.
  - p=63, in_m=0x800000000001 -> out_q=0, sticky=1, zero=1.
  - in_v=0, in_m=0 -> out_q=0, zero=1, sticky=0.
- Sticky: in_m=0x800000000003, p=1 -> out_q=0x400000000001, sticky=1.
- Backpressure: stream 8 beats back-to-back with out_ready=0 for cycles 4-7 -> in_ready=0 during the stall, all 8 results emerge in order, none lost or duplicated, and outputs are stable while held.
- Random: 10k random (a, LZD(a)) pairs built from a 48-bit a normalized by its LZD count, with random out_ready -> every out_q equals a, and sticky=0.
